// File: rtl/param_updown_counter_if.sv
// Control and status bundle for param_updown_counter.
// The master side drives the strobes and limits, and the counter (slave) returns its registered status.
interface param_updown_counter_if #(
    parameter int WIDTH = 8
);
    // Strobes are level-sampled on every rising clock edge. There is no
    // valid/ready handshake: load, en and clr_ovf take effect on the edge
    // that samples them high. out, tc and ovf change only on that edge.
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] max_val;
    logic             clr_ovf;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             ovf;

    modport master (
        output en, up, load, load_val, max_val, clr_ovf,
        input  out, tc, ovf
    );

    modport slave (
        input  en, up, load, load_val, max_val, clr_ovf,
        output out, tc, ovf
    );
endinterface

// File: rtl/param_updown_counter.sv
// Up/down counter over the range 0..max_val, with parallel load, an enable prescaler and wrap/saturate mode.
// Produces a registered count, a one-cycle terminal-count pulse and a sticky overflow flag.
module param_updown_counter #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    param_updown_counter_if.slave bus
);
    localparam bit SAT = (SATURATE != 0);

    logic step;
    logic at_max;
    logic at_zero;
    logic out_of_range;

    assign at_max       = (bus.out == bus.max_val);
    assign at_zero      = (bus.out == '0);
    assign out_of_range = (bus.out > bus.max_val);

    generate
        if (PRESCALE <= 1) begin : g_no_prescale
            assign step = bus.en & ~bus.load;
        end else begin : g_prescale
            localparam int PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] pre_cnt;

            assign step = bus.en & ~bus.load & (pre_cnt == PRE_LAST);

            // A load restarts the prescale period. The direction input has no effect on the prescaler.
            always_ff @(posedge clk) begin
                if (reset) begin
                    pre_cnt <= '0;
                end else if (bus.load) begin
                    pre_cnt <= '0;
                end else if (bus.en) begin
                    if (pre_cnt == PRE_LAST) begin
                        pre_cnt <= '0;
                    end else begin
                        pre_cnt <= pre_cnt + 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out <= '0;
            bus.tc  <= 1'b0;
            bus.ovf <= 1'b0;
        end else begin
            bus.tc <= 1'b0;
            if (bus.clr_ovf) begin
                bus.ovf <= 1'b0;
            end
            if (bus.load) begin
                bus.out <= (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;
            end else if (step) begin
                // A limit that was lowered below the count pulls the count back quietly.
                if (out_of_range) begin
                    bus.out <= bus.max_val;
                end else if (bus.up) begin
                    if (at_max) begin
                        bus.out <= SAT ? bus.out : '0;
                        bus.tc  <= 1'b1;
                        bus.ovf <= 1'b1;
                    end else begin
                        bus.out <= bus.out + 1'b1;
                    end
                end else begin
                    if (at_zero) begin
                        bus.out <= SAT ? bus.out : bus.max_val;
                        bus.tc  <= 1'b1;
                        bus.ovf <= 1'b1;
                    end else begin
                        bus.out <= bus.out - 1'b1;
                    end
                end
            end
        end
    end
endmodule
